config_chain_loader: RTL
========================

Name: config_chain_loader

Overview:
Configuration front-end that sits directly upstream of the crossbar programming chain. It accepts 32-bit configuration words from a valid/ready source, such as a config memory or bus bridge. It drives them into the head of the shift chain (`prog_i`/`prog_shft` of the first crossbar), one word per accepted handshake, and counts exactly CHAIN_LEN words before flagging completion. The chain shifts only on cycles where this block asserts `prog_shft`, so source stalls never corrupt the chain.

Parameters:
- DATA_W, 32, configuration word width; equals the chain `prog_i` width.
- CHAIN_LEN, 75, number of words needed to fill the chain.
- CNT_W, 8, word-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- nres  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- cfg_data  input  DATA_W  configuration word from source.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- prog_o  output  DATA_W  word to chain head (connects to first crossbar `prog_i`).
- prog_shft  output  1  chain shift enable (connects to all crossbar `prog_shft`).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  checksum mismatch flag; always 0 without CFG_CHECKSUM_EN.

Behaviour:
- Reset (nres=0, asynchronous):
  - state=IDLE, count=0.
  - prog_o=0, prog_shft=0, cfg_ready=0, busy=0, done=0, err=0.
  - Any partially loaded chain content is don't-care; the block never tries to resume a load after reset.
- States: IDLE, LOAD, DRAIN, CHECK (only with CFG_CHECKSUM_EN), DONE.
- IDLE:
  - cfg_ready=0.
  - start=1 at an edge: count<=0, err<=0, checksum accumulator<=0, state<=LOAD.
- LOAD:
  - cfg_ready=1 combinationally.
  - Accept = cfg_valid && cfg_ready at a rising edge.
  - On accept: prog_o<=cfg_data, prog_shft<=1, count<=count+1. If count==CHAIN_LEN-1, state<=DRAIN.
  - No accept: prog_shft<=0 and prog_o holds its last value.
  - Latency: a word accepted at edge E is on prog_o/prog_shft during E..E+1 and is sampled by the chain at E+1.
- DRAIN:
  - cfg_ready=0.
  - prog_shft<=0 at the next edge (the last word is the final shift).
  - Next state: CHECK if CFG_CHECKSUM_EN is defined, else DONE.
- DONE:
  - done=1 for exactly one cycle, prog_shft=0, then state<=IDLE.
  - done rises on the same edge where prog_shft falls after the last word.
- Exactly CHAIN_LEN prog_shft-high cycles occur per load, regardless of cfg_valid gaps.
- start in any state other than IDLE is ignored; count and state are unaffected.
- A start pulse on the cycle done is high is also ignored, since the block is in DONE.
- cfg_valid while not in LOAD/CHECK is ignored; no data is consumed.
- busy=1 in LOAD, DRAIN, CHECK and DONE.
- err is sticky until the next honoured start.
- count never exceeds CHAIN_LEN; there is no wrap-around.

Optional Feature:
- Macro: CFG_CHECKSUM_EN.
- Defined:
  - Every word accepted in LOAD is XORed into a DATA_W accumulator.
  - After DRAIN, the CHECK state raises cfg_ready=1 (prog_shft stays 0) and waits for one trailer word.
  - On trailer accept: err<=(trailer != accumulator), state<=DONE.
  - The trailer is never shifted into the chain.
- Not defined: CHECK state, accumulator and trailer are absent; err is tied 0; DRAIN goes directly to DONE.

Test Plan:
- Reset: hold nres=0 with random cfg_valid/start -> prog_o=0, prog_shft=0, cfg_ready=0, busy=0, done=0, err=0; releasing nres without start -> state stays IDLE.
- Full streaming load: start, then words 0x00000000..0x0000004A with cfg_valid=1 continuously -> prog_shft high for exactly 75 consecutive cycles; prog_o carries 0x0..0x4A in order, one cycle after each accept; done pulses once as prog_shft falls.
- Gapped source: cfg_valid toggles 1/0 each cycle over 75 words -> prog_shft pattern mirrors accepts; 75 high cycles total; chain content identical to the streaming case.
- Start while busy: pulse start after 10 words -> ignored; the load completes after 65 more words with a single done pulse.
- Reset mid-load: assert nres=0 after 30 words -> all outputs drop to 0 immediately; a subsequent start loads a fresh 75 words and count starts from 0.
- CFG_CHECKSUM_EN:
  - 75 words whose XOR is 0x5A5A5A5A, trailer 0x5A5A5A5A -> err=0 at done; the trailer does not cause a prog_shft pulse.
  - Repeat with trailer 0x00000000 -> err=1 at done, and err stays 1 until the next start.

Source files
------------

// File: rtl/config_chain_loader.sv
// Streams CHAIN_LEN configuration words from a valid/ready source into the crossbar programming chain.
// Define CFG_CHECKSUM_EN to verify an XOR trailer word after the load and report mismatches on err.
module config_chain_loader #(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 75,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [DATA_W-1:0] prog_o,
    output logic              prog_shft,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

`ifdef CFG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             in_load;
    logic             load_accept;
    logic             last_word;

    assign in_load     = (state == S_LOAD);
    assign load_accept = in_load & cfg_valid;
    assign last_word   = (count == LAST_IDX);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

`ifdef CFG_CHECKSUM_EN
    logic              in_check;
    logic              trailer_accept;
    logic [DATA_W-1:0] checksum;

    assign in_check       = (state == S_CHECK);
    assign trailer_accept = in_check & cfg_valid;
    assign cfg_ready      = in_load | in_check;
`else
    assign cfg_ready = in_load;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_LOAD;
            S_LOAD:  if (load_accept && last_word) next_state = S_DRAIN;
`ifdef CFG_CHECKSUM_EN
            S_DRAIN: next_state = S_CHECK;
            S_CHECK: if (trailer_accept) next_state = S_DONE;
`else
            S_DRAIN: next_state = S_DONE;
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            count     <= '0;
            prog_o    <= '0;
            prog_shft <= 1'b0;
        end else begin
            // The chain shifts only on accepted words; stalls leave it untouched.
            prog_shft <= load_accept;
            if (load_accept) begin
                prog_o <= cfg_data;
                count  <= count + 1'b1;
            end else if (state == S_IDLE && start) begin
                count <= '0;
            end
        end
    end

`ifdef CFG_CHECKSUM_EN
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            checksum <= '0;
            err      <= 1'b0;
        end else if (state == S_IDLE && start) begin
            checksum <= '0;
            err      <= 1'b0;
        end else if (load_accept) begin
            checksum <= checksum ^ cfg_data;
        end else if (trailer_accept) begin
            // err is sticky until the next honoured start.
            err <= (cfg_data != checksum);
        end
    end
`endif

endmodule
